// File: rtl/wigend_pkg.sv
// Shared definitions for the Wiegand-26 receiver: frame length, FSM states,
// error codes, default timing and the 26-bit parity helper.
package wigend_pkg;

  localparam int NBITS         = 26;
  localparam int DEF_MIN_PULSE = 20;
  localparam int DEF_MAX_PULSE = 2000;
  localparam int DEF_FRAME_GAP = 10000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    GAP   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE = 2'd0;
  localparam err_code_t ERR_LEN  = 2'd1;
  localparam err_code_t ERR_LINE = 2'd2;
  localparam err_code_t ERR_PAR  = 2'd3;

  // Result handed from the FSM to the bus-side output registers.
  typedef struct packed {
    logic             err;
    err_code_t        code;
    logic [NBITS-1:0] data;
  } frame_t;

  // Leading bit: even parity over the upper 13 bits.
  // Trailing bit: odd parity over the lower 13 bits.
  function automatic logic parity_ok(input logic [NBITS-1:0] f);
    return (^f[25:13] == 1'b0) && (^f[12:0] == 1'b1);
  endfunction

endpackage

// File: rtl/wigend_sync.sv
// Two-flop synchronizer for the asynchronous Wiegand lines plus a third
// history stage for rise/fall detection. lvl lags the pin by two cycles.
module wigend_sync #(
  parameter int NUM_LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] din,
  output logic [NUM_LANES-1:0] lvl,
  output logic [NUM_LANES-1:0] rise,
  output logic [NUM_LANES-1:0] fall
);

  // Stage-major pipe: [0] metastability flop, [1] synced level, [2] history.
  logic [2:0][NUM_LANES-1:0] pipe;

  // Shift the raw lines through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst) pipe <= '0;
    else      pipe <= {pipe[1:0], din};
  end

  assign lvl  = pipe[1];
  assign rise = pipe[1] & ~pipe[2];
  assign fall = ~pipe[1] & pipe[2];

endmodule

// File: rtl/wigend_in.sv
// Wiegand-26 receiver: measures D0/D1 pulses, shifts bits in MSB first,
// closes the frame on an idle timeout and publishes it with valid/ack.
// Optional build macro: WIGEND_IN_PARITY_CHECK_EN adds the 26-bit parity check.
// The interrupt output is named int_n because "int" is a reserved word.
module wigend_in
  import wigend_pkg::*;
#(
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int MAX_PULSE = DEF_MAX_PULSE,
  parameter int FRAME_GAP = DEF_FRAME_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       wigend,
  output logic [NBITS-1:0] data,
  output logic             valid,
  input  logic             ack,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             overrun,
  output logic             int_n
);

  localparam logic [11:0] MINP  = 12'(MIN_PULSE);
  localparam logic [11:0] MAXP  = 12'(MAX_PULSE);
  localparam logic [15:0] GAPM1 = 16'(FRAME_GAP - 1);
  localparam logic [4:0]  NB5   = 5'(NBITS);

  logic [1:0] lvl, rise, fall;

  wigend_sync #(.NUM_LANES(2)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (wigend),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  state_e           state_q, state_d;
  logic [11:0]      pcnt_q, pcnt_d;     // high time of current pulse
  logic [15:0]      lcnt_q, lcnt_d;     // low time in GAP / ERR
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic             line_q, line_d;     // which line carries the pulse
  err_code_t        ecode_q, ecode_d;
  logic             pub;
  frame_t           pub_frm;

  // FSM and datapath state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      lcnt_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      line_q   <= 1'b0;
      ecode_q  <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      lcnt_q   <= lcnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      line_q   <= line_d;
      ecode_q  <= ecode_d;
    end
  end

  // Next-state logic: pulse qualification, bit shifting, frame close.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    lcnt_d   = lcnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    line_d   = line_q;
    ecode_d  = ecode_q;
    pub      = 1'b0;
    pub_frm  = '{err: 1'b0, code: ERR_NONE, data: shreg_q};

    case (state_q)
      IDLE: begin
        if (|lvl) begin
          state_d  = PULSE;
          pcnt_d   = 12'd1;
          bitcnt_d = '0;
          shreg_d  = '0;
          line_d   = lvl[1];
        end
      end

      PULSE: begin
        if (&lvl || pcnt_q > MAXP) begin
          state_d = ERR;
          ecode_d = ERR_LINE;
          lcnt_d  = '0;
        end else if (fall[line_q]) begin
          // The falling-edge cycle is the first low cycle of the gap.
          lcnt_d = 16'd1;
          if (pcnt_q >= MINP) begin
            shreg_d  = {shreg_q[NBITS-2:0], line_q};
            bitcnt_d = (bitcnt_q == 5'd31) ? bitcnt_q : bitcnt_q + 5'd1;
            state_d  = GAP;
          end else begin
            state_d = (bitcnt_q != '0) ? GAP : IDLE;
          end
        end else begin
          pcnt_d = (pcnt_q == 12'hFFF) ? pcnt_q : pcnt_q + 12'd1;
        end
      end

      GAP: begin
        if (|rise) begin
          state_d = PULSE;
          pcnt_d  = 12'd1;
          line_d  = rise[1];
        end else if (lcnt_q == GAPM1) begin
          state_d = DONE;
        end else begin
          lcnt_d = lcnt_q + 16'd1;
        end
      end

      DONE: begin
        pub     = 1'b1;
        state_d = IDLE;
        if (bitcnt_q != NB5) begin
          pub_frm.err  = 1'b1;
          pub_frm.code = ERR_LEN;
        end
`ifdef WIGEND_IN_PARITY_CHECK_EN
        else if (!parity_ok(shreg_q)) begin
          pub_frm.err  = 1'b1;
          pub_frm.code = ERR_PAR;
        end
`endif
      end

      ERR: begin
        // Hold off until the bus has been quiet for a full frame gap.
        if (|lvl) begin
          lcnt_d = '0;
        end else if (lcnt_q == GAPM1) begin
          pub          = 1'b1;
          pub_frm.err  = 1'b1;
          pub_frm.code = ecode_q;
          state_d      = IDLE;
        end else begin
          lcnt_d = lcnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Bus-side frame register: ack is applied before a same-cycle publish.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      overrun  <= 1'b0;
    end else if (pub) begin
      if (valid && !ack) begin
        overrun <= 1'b1;
      end else begin
        data     <= pub_frm.data;
        err      <= pub_frm.err;
        err_code <= pub_frm.code;
        valid    <= 1'b1;
        overrun  <= 1'b0;
      end
    end else if (valid && ack) begin
      valid    <= 1'b0;
      overrun  <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end
  end

  assign int_n = ~valid;

endmodule

// File: tb/tb_wigend_in.sv
// Directed bench for wigend_in with shortened timing parameters.
module tb_wigend_in;
  import wigend_pkg::*;

  localparam int TMIN = 8;
  localparam int TMAX = 40;
  localparam int TGAP = 100;
  localparam int PW   = 12;   // pulse width
  localparam int SP   = 18;   // inter-pulse space

`ifdef WIGEND_IN_PARITY_CHECK_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       wigend = 2'b00;
  logic             ack = 1'b0;
  logic [NBITS-1:0] data;
  logic             valid, err, overrun, int_n;
  logic [1:0]       err_code;

  int vectors = 0;
  int miscompares = 0;

  wigend_in #(.MIN_PULSE(TMIN), .MAX_PULSE(TMAX), .FRAME_GAP(TGAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .wigend   (wigend),
    .data     (data),
    .valid    (valid),
    .ack      (ack),
    .err      (err),
    .err_code (err_code),
    .overrun  (overrun),
    .int_n    (int_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int line, input int w);
    wigend[line] = 1'b1;
    tick(w);
    wigend = 2'b00;
  endtask

  // Sends bits v[25] downward, n pulses; optional 3-cycle D1 glitch
  // inside the space after pulse index glitch_at. Ends right at the
  // last falling edge.
  task automatic send_frame(input logic [25:0] v, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      pulse(int'(v[25-i]), PW);
      if (i != n - 1) begin
        if (i == glitch_at) begin
          tick(7);
          wigend[1] = 1'b1;
          tick(3);
          wigend[1] = 1'b0;
          tick(SP - 10);
        end else begin
          tick(SP);
        end
      end
    end
  endtask

  // valid must rise exactly TGAP+3 cycles after the last falling edge.
  task automatic expect_pub(input string tag);
    tick(TGAP + 2);
    check({tag, "_early"}, 32'(valid), 32'd0);
    tick(1);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_int"}, 32'(int_n), 32'd0);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check({tag, "_ackvalid"}, 32'(valid), 32'd0);
    check({tag, "_ackint"}, 32'(int_n), 32'd1);
    tick(5);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!valid && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(valid), 32'd1);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    tick(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_int", 32'(int_n), 32'd1);
    check("rst_data", 32'(data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b1;
    tick(5);

    // Clean frame 0000001
    send_frame(26'h0000001, 26, -1);
    expect_pub("f1");
    check("f1_data", 32'(data), 32'h0000001);
    check("f1_err", 32'(err), 32'd0);
    check("f1_code", 32'(err_code), 32'd0);
    do_ack("f1");

    // Frame 0000003: lower half has even parity
    send_frame(26'h0000003, 26, -1);
    expect_pub("f3");
    check("f3_data", 32'(data), 32'h0000003);
    check("f3_err", 32'(err), 32'(PAR));
    check("f3_code", 32'(err_code), PAR ? 32'd3 : 32'd0);
    do_ack("f3");

    // 25 pulses -> length error
    send_frame(26'h2AAAAAA, 25, -1);
    expect_pub("len");
    check("len_err", 32'(err), 32'd1);
    check("len_code", 32'(err_code), 32'd1);
    check("len_data", 32'(data), 32'h1555555);
    do_ack("len");

    // Both lines high mid-frame -> line fault after idle gap
    send_frame(26'h3FFFFFF, 5, -1);
    tick(SP);
    wigend = 2'b11;
    tick(100);
    wigend = 2'b00;
    tick(TGAP - 10);
    check("line_nopub", 32'(valid), 32'd0);
    wait_valid("line", 40);
    check("line_err", 32'(err), 32'd1);
    check("line_code", 32'(err_code), 32'd2);
    do_ack("line");

    // Recovery frame
    send_frame(26'h0000001, 26, -1);
    expect_pub("rec");
    check("rec_data", 32'(data), 32'h0000001);
    check("rec_err", 32'(err), 32'd0);
    do_ack("rec");

    // Short D1 glitch between bits is ignored
    send_frame(26'h0000001, 26, 10);
    expect_pub("glt");
    check("glt_data", 32'(data), 32'h0000001);
    check("glt_err", 32'(err), 32'd0);
    do_ack("glt");

    // Two frames without ack -> first retained, overrun set
    send_frame(26'h0000001, 26, -1);
    expect_pub("ovA");
    tick(5);
    send_frame(26'h0000003, 26, -1);
    tick(TGAP + 10);
    check("ov_valid", 32'(valid), 32'd1);
    check("ov_data", 32'(data), 32'h0000001);
    check("ov_flag", 32'(overrun), 32'd1);
    do_ack("ov");
    check("ov_clr", 32'(overrun), 32'd0);

    // Put a frame on the outputs, then reset in the middle of the next one
    send_frame(26'h0000001, 26, -1);
    expect_pub("pre");
    send_frame(26'h0000001, 10, -1);
    tick(5);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_data", 32'(data), 32'd0);
    check("mrst_int", 32'(int_n), 32'd1);
    check("mrst_ovr", 32'(overrun), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    tick(TGAP + 20);
    check("mrst_nopub", 32'(valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
